sync_fifo_param: RTL

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param_if.sv | 35 +++
 rtl/sync_fifo_param.sv | 100 ++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read handshake, data, flags and count of one FIFO.
// master drives wr_en/wr_data/rd_en; slave (the FIFO) drives everything else.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty,
    input  almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty,
    output almost_full, almost_empty, count,
    output overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO, registered read or first-word-fall-through.
// Ports: clk, rst_n (async active-low), bus (sync_fifo_param_if.slave).
// Macro SYNC_FIFO_PARAM_FWFT_EN selects FWFT; default is one-cycle registered read.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_TH  = DEPTH - 2,
  parameter int AE_TH  = 2
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF_V = (ADDR_W+1)'(AF_TH);
  localparam logic [ADDR_W:0] AE_V = (ADDR_W+1)'(AE_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, unf_q;
  logic              empty, full;
  logic              wr_acc, rd_acc;

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // Acceptance looks only at registered flags: a full FIFO
  // refuses a write even when a read frees a slot this cycle.
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ONE : rd_ptr_q;
    count_d  = count_q;
    unique case (1'b1)
      (wr_acc && !rd_acc): count_d = count_q + ONE;
      (rd_acc && !wr_acc): count_d = count_q - ONE;
      default:             count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= bus.wr_en && full;
      unf_q    <= bus.rd_en && empty;
    end
  end

  // Storage is never cleared; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc && rst_n)
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
  end

`ifdef SYNC_FIFO_PARAM_FWFT_EN
  // Head word shown straight from storage; rd_en just pops it.
  assign bus.rd_data  = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign bus.rd_valid = !empty;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc)
        rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AF_V);
  assign bus.almost_empty = (count_q <= AE_V);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
